rr_resource_share: RTL and testbench
====================================

// Module: rr_resource_share
// PURPOSE
//  Round-robin arbiter and scheduler that time-shares one fixed-latency, fully
//  pipelined resource among N requesters, e.g. a multiplier built from
//  Register/Prev stages.
//  Each cycle at most one request is granted and its operand is muxed to the
//  resource. A tag pipeline routes the completion strobe back to the owning
//  requester exactly LATENCY cycles later. Sits between requester FSMs and a
//  shared datapath unit.
// PARAMETERS
//  N        4   number of requesters; must be >= 2; need not be a power of 2
//  WIDTH    32  operand/result width in bits
//  LATENCY  2   resource latency in cycles, res_go -> res_out valid; must be >= 1
//  PW       $clog2(N) (local)           pointer/tag width
//  CW       $clog2(LATENCY+1) (local)   inflight counter width
// PORTS
//  clk       in   1        clock, all state on posedge
//  reset     in   1        synchronous, active-high
//  req       in   N        per-requester request, level; bit i = requester i
//  req_data  in   N*WIDTH  operands; requester i at [i*WIDTH +: WIDTH]
//  grant     out  N        one-hot (or zero) grant, combinational, this cycle
//  res_go    out  1        issue strobe to resource; = |grant
//  res_in    out  WIDTH    operand of granted requester; 0 when no grant
//  res_out   in   WIDTH    resource result, valid LATENCY cycles after res_go
//  done      out  N        one-hot completion; bit i = result for requester i
//  out_data  out  WIDTH    = res_out; meaningful only when |done
//  inflight  out  CW       number of issued-but-not-completed operations
// BEHAVIOUR
//  - State: rr pointer ptr[PW-1:0]; tag pipeline of LATENCY stages {vld, idx[PW-1:0]}.
//  - Reset (sync, high): ptr<=0; all stage vld<=0; idx don't-care.
//    While reset is high, grant=0 and res_go=0.
//    One cycle after reset deasserts: done=0, inflight=0, res_in=0 if req=0.
//  - Arbitration: the winner is the first i with req[i]=1, searched ptr, ptr+1,
//    ..., N-1, 0, ..., ptr-1 (mod N).
//    grant=onehot(winner), computed combinationally the same cycle (0-cycle latency).
//    If req=0: grant=0, res_go=0, res_in=0, ptr holds.
//  - Pointer update: on a grant of i, ptr <= (i==N-1) ? 0 : i+1 (explicit wrap,
//    no reliance on power-of-2 overflow).
//  - No backpressure: the resource accepts every cycle, so a grant is an issue.
//    A requester that holds req after a grant competes again next cycle.
//  - Tag pipeline: stage0 <= {res_go, winner}; stage k <= stage k-1 for
//    k=1..LATENCY-1; shifts every cycle.
//  - done[i] = vld && idx==i at stage LATENCY-1, a register output, no comb
//    path from req. Net effect: grant of i at cycle t gives done[i]=1 exactly
//    at cycle t+LATENCY.
//  - At most one done bit per cycle. Back-to-back issues give back-to-back
//    dones in grant order.
//  - inflight = popcount of stage vld bits; range 0..LATENCY; never overflows.
//  - Simultaneous issue and completion in one cycle: both take effect, and
//    inflight reflects the register contents after the edge.
//  - Reset mid-operation: all vld cleared. Outstanding results are dropped and no
//    done fires for them, even though res_out may still change.
//  - out_data is a pure pass-through; the block stores no result data.
//  - N=2 corner: PW=1, and the wrap rule still holds (grant 1 -> ptr=0).
// TESTING (N=4, WIDTH=32, LATENCY=2 unless stated)
//  1. Reset, then req=4'b1111 for 4 cycles, data i=0x10+i
//     -> grant 0001,0010,0100,1000; res_in 0x10..0x13;
//     done same sequence starting 2 cycles after the first grant.
//  2. Hold req=4'b0100 for 5 cycles -> grant=0100 every cycle; res_go=1;
//     done=0100 from cycle 3 on; inflight settles at 2.
//  3. Wrap: grant requester 3, then req=4'b1001 -> grant=0001.
//     Then with req=1001 held -> grant=1000 next.
//  4. Idle hold: grant requester 1, req=0 for 3 cycles (grant=0, res_go=0,
//     res_in=0), then req=1111 -> grant=0100.
//  5. Reset mid-flight: grant at t, reset high at t+1 -> done=0 at t+2 and t+3;
//     inflight=0 after reset.
//  6. Data return: issue requester 2, drive res_out=0xDEADBEEF at t+2
//     -> done=0100 and out_data=0xDEADBEEF at t+2. Repeat with LATENCY=1 and
//     LATENCY=4, and with N=3 (wrap 2->0).

Source files
------------

// File: rtl/rr_resource_share.sv
// Round-robin scheduler that time-shares one fixed-latency pipelined resource among N requesters.
// A tag pipeline returns the completion strobe to the owning requester LATENCY cycles later.
module rr_resource_share #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned PW     = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CW     = $clog2(LATENCY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       grant,
  output logic               res_go,
  output logic [WIDTH-1:0]   res_in,
  input  logic [WIDTH-1:0]   res_out,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      inflight
);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      winner;
  logic               any_req;
  logic [PW-1:0]      hi_win, lo_win;
  logic               hi_any;
  logic [LATENCY-1:0] vld_q;
  logic [PW-1:0]      idx_q [LATENCY];

  // Lowest requester at or above the pointer wins; otherwise the lowest overall.
  always_comb begin
    hi_win  = '0;
    lo_win  = '0;
    hi_any  = 1'b0;
    any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_win  = PW'(i);
        any_req = 1'b1;
        if (PW'(i) >= ptr_q) begin
          hi_win = PW'(i);
          hi_any = 1'b1;
        end
      end
    end
    winner = hi_any ? hi_win : lo_win;
  end

  always_comb begin
    res_go = any_req && !reset;
    grant  = '0;
    res_in = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = res_go && (winner == PW'(i));
      if (grant[i]) begin
        res_in = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (res_go) begin
      ptr_d = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= res_go;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  // Tags are only meaningful alongside their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    idx_q[0] <= winner;
    for (int k = 1; k < LATENCY; k++) begin
      idx_q[k] <= idx_q[k-1];
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < N; i++) begin
      done[i] = vld_q[LATENCY-1] && (idx_q[LATENCY-1] == PW'(i));
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      inflight = inflight + CW'(vld_q[k]);
    end
  end

  assign out_data = res_out;

endmodule

// File: tb/tb_rr_resource_share.sv
// Bench for rr_resource_share: four configurations driven in lockstep and checked against a
// transaction-level model (issue list with completion times, modular round-robin search).
module tb_rr_resource_share;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [3:0]   req;
  logic [31:0]  dw [4];
  logic [127:0] req_data;
  logic [31:0]  res_out;
  assign req_data = {dw[3], dw[2], dw[1], dw[0]};

  logic [3:0]  grant0, done0;
  logic [2:0]  grant1, done1;
  logic [3:0]  grant2, done2;
  logic [1:0]  grant3, done3;
  logic        go0, go1, go2, go3;
  logic [31:0] ri0, ri1, ri2, ri3, od0, od1, od2, od3;
  logic [1:0]  inf0;
  logic [0:0]  inf1;
  logic [2:0]  inf2;
  logic [1:0]  inf3;

  rr_resource_share #(.N(4), .WIDTH(32), .LATENCY(2)) u_d0 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant0), .res_go(go0),
    .res_in(ri0), .res_out(res_out), .done(done0), .out_data(od0), .inflight(inf0));
  rr_resource_share #(.N(3), .WIDTH(32), .LATENCY(1)) u_d1 (
    .clk(clk), .reset(reset), .req(req[2:0]), .req_data(req_data[95:0]), .grant(grant1),
    .res_go(go1), .res_in(ri1), .res_out(res_out), .done(done1), .out_data(od1),
    .inflight(inf1));
  rr_resource_share #(.N(4), .WIDTH(32), .LATENCY(4)) u_d2 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant2), .res_go(go2),
    .res_in(ri2), .res_out(res_out), .done(done2), .out_data(od2), .inflight(inf2));
  rr_resource_share #(.N(2), .WIDTH(32), .LATENCY(3)) u_d3 (
    .clk(clk), .reset(reset), .req(req[1:0]), .req_data(req_data[63:0]), .grant(grant3),
    .res_go(go3), .res_in(ri3), .res_out(res_out), .done(done3), .out_data(od3),
    .inflight(inf3));

  logic [3:0]  g [4];
  logic [3:0]  dn [4];
  logic        go [4];
  logic [31:0] ri [4];
  logic [31:0] od [4];
  logic [2:0]  inf [4];
  assign g[0] = grant0;           assign g[1] = {1'b0, grant1};
  assign g[2] = grant2;           assign g[3] = {2'b0, grant3};
  assign dn[0] = done0;           assign dn[1] = {1'b0, done1};
  assign dn[2] = done2;           assign dn[3] = {2'b0, done3};
  assign go[0] = go0;  assign go[1] = go1;  assign go[2] = go2;  assign go[3] = go3;
  assign ri[0] = ri0;  assign ri[1] = ri1;  assign ri[2] = ri2;  assign ri[3] = ri3;
  assign od[0] = od0;  assign od[1] = od1;  assign od[2] = od2;  assign od[3] = od3;
  assign inf[0] = {1'b0, inf0};   assign inf[1] = {2'b0, inf1};
  assign inf[2] = inf2;           assign inf[3] = {1'b0, inf3};

  // Reference model: issue list with completion times, pointer per configuration.
  typedef struct {
    int d;
    int t;
    int idx;
  } iss_t;
  iss_t q[$];
  int nn [4] = '{4, 3, 4, 2};
  int ll [4] = '{2, 1, 4, 3};
  int ptr [4];
  int now = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, d, now, obs, exp);
    end
  endtask

  function automatic int pick(input int d, input logic [3:0] rq);
    for (int k = 0; k < nn[d]; k++) begin
      int i;
      i = (ptr[d] + k) % nn[d];
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check all outputs mid-cycle, then advance the model at the edge.
  // xg/xd are optional hand-written expectations for configuration 0 (-1 = none).
  task automatic cycle(input logic rst, input logic [3:0] rq, input logic [31:0] ro,
                       input int xg, input int xd);
    int          w [4];
    logic [3:0]  eg, ed;
    logic [31:0] eri;
    int          einf;
    reset   = rst;
    req     = rq;
    res_out = ro;
    #4;
    for (int d = 0; d < 4; d++) begin
      w[d] = rst ? -1 : pick(d, rq);
      eg   = (w[d] >= 0) ? 4'(1 << w[d]) : 4'd0;
      eri  = (w[d] >= 0) ? dw[w[d]] : 32'd0;
      ed   = '0;
      einf = 0;
      foreach (q[j]) begin
        if (q[j].d == d) begin
          if (q[j].t + ll[d] == now) ed = 4'(1 << q[j].idx);
          if (q[j].t + ll[d] >= now) einf++;
        end
      end
      chk("grant", d, 32'(g[d]), 32'(eg));
      chk("res_go", d, 32'(go[d]), 32'(eg != 0));
      chk("res_in", d, ri[d], eri);
      chk("done", d, 32'(dn[d]), 32'(ed));
      chk("inflight", d, 32'(inf[d]), 32'(einf));
      if (ed != 0) chk("out_data", d, od[d], ro);
    end
    if (xg >= 0) chk("spec_grant", 0, 32'(g[0]), 32'(xg));
    if (xd >= 0) chk("spec_done", 0, 32'(dn[0]), 32'(xd));
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        ptr[d] = 0;
        for (int j = q.size() - 1; j >= 0; j--) if (q[j].d == d) q.delete(j);
      end else begin
        if (w[d] >= 0) begin
          q.push_back('{d: d, t: now, idx: w[d]});
          ptr[d] = (w[d] + 1) % nn[d];
        end
        for (int j = q.size() - 1; j >= 0; j--)
          if (q[j].d == d && q[j].t + ll[d] <= now) q.delete(j);
      end
    end
    now++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      dw[i]  = 32'h10 + 32'(i);
      ptr[i] = 0;
    end
    reset   = 1'b1;
    req     = '0;
    res_out = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'b0000, 32'h0, 0, -1);
    cycle(1'b1, 4'b0000, 32'h0, 0, -1);

    // Full contention rotates through all requesters, completions two cycles later.
    cycle(1'b0, 4'b1111, $urandom, 4'b0001, 4'b0000);
    cycle(1'b0, 4'b1111, $urandom, 4'b0010, 4'b0000);
    cycle(1'b0, 4'b1111, $urandom, 4'b0100, 4'b0001);
    cycle(1'b0, 4'b1111, $urandom, 4'b1000, 4'b0010);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b0100);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b1000);

    // A single held requester keeps winning.
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, 4'b0000);
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, 4'b0000);
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, 4'b0100);
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, 4'b0100);
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, 4'b0100);

    // Pointer wrap from requester 3 back to 0.
    cycle(1'b0, 4'b1000, $urandom, 4'b1000, 4'b0100);
    cycle(1'b0, 4'b1001, $urandom, 4'b0001, 4'b0100);
    cycle(1'b0, 4'b1001, $urandom, 4'b1000, 4'b1000);

    // Idle cycles hold the pointer.
    cycle(1'b0, 4'b0010, $urandom, 4'b0010, 4'b0001);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b1000);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b0010);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b1111, $urandom, 4'b0100, 4'b0000);
    cycle(1'b0, 4'b0000, $urandom, -1, -1);
    cycle(1'b0, 4'b0000, $urandom, -1, -1);

    // Reset one cycle after an issue drops the outstanding result.
    cycle(1'b0, 4'b0001, $urandom, 4'b0001, -1);
    cycle(1'b1, 4'b0000, $urandom, 4'b0000, -1);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, $urandom, 4'b0000, 4'b0000);

    // Result data returned on the completion cycle of requester 2.
    cycle(1'b0, 4'b0100, $urandom, 4'b0100, -1);
    cycle(1'b0, 4'b0000, 32'hDEADBEEF, -1, -1);
    cycle(1'b0, 4'b0000, 32'hDEADBEEF, -1, 4'b0100);
    chk("out_passthru", 0, od[0], 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'hDEADBEEF, -1, -1);

    // Random traffic with occasional resets and fresh operands.
    for (int n = 0; n < 500; n++) begin
      if (n % 8 == 0) for (int i = 0; i < 4; i++) dw[i] = $urandom;
      cycle(($urandom_range(39) == 0), 4'($urandom), $urandom, -1, -1);
    end
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b0000, $urandom, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
